pwm_ramp_gen: RTL and testbench
===============================

Name: pwm_ramp_gen

Overview:
Reference-ramp generator for the ramp-compare ADC, driving the PWM that feeds the RC filter to produce Vref. It steps duty_cycle upward once every SETTLE_PERIODS PWM periods, from 0 to MAX_DUTY. The duty_cycle bus goes to the ADC result-capture stage, which latches it on the comparator's falling edge. The capture stage's data_ready pulse returns here as sample_taken, which aborts the ramp and restarts it after a discharge interval.

Parameters:
PERIOD, 256, PWM period in clk cycles; legal range 2..65535.
STEP, 1, duty increment per ramp step.
MAX_DUTY, 255, final duty value; must be at most PERIOD.
SETTLE_PERIODS, 4, PWM periods per step, and length of the discharge interval; must be at least 1.

Ports:
clk  input  1  system clock; sole clock domain.
reset  input  1  asynchronous, active-low reset; deassertion assumed synchronous to clk.
enable  input  1  level; 1 = run ramp cycles, 0 = return to IDLE.
sample_taken  input  1  one-cycle pulse from the capture stage: comparator crossed.
pwm_out  output  1  registered PWM drive to the RC filter.
duty_cycle  output  16  current duty value; also the sampled code.
ramp_start  output  1  one-cycle pulse on entry to RAMP (duty = 0).
ramp_done  output  1  one-cycle pulse when MAX_DUTY has been held SETTLE_PERIODS periods without a sample.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async):
  - State = IDLE; cnt = 0; per_cnt = 0; abort flag = 0.
  - Outputs: pwm_out = 0, duty_cycle = 0, ramp_start = 0, ramp_done = 0, busy = 0.
- cnt (16 bit):
  - Counts 0..PERIOD-1 and wraps to 0.
  - Advances every cycle outside IDLE; held at 0 in IDLE.
  - period_tick = (cnt == PERIOD-1), internal.
- pwm_out:
  - Registered: pwm_out <= (state != IDLE) && (cnt < duty_cycle).
  - One-cycle latency from cnt. duty 0 gives constant 0; duty = PERIOD gives constant 1.
- duty_cycle:
  - Changes only on a period_tick cycle, so it is glitch-free within a period.
  - Exceptions: reset, and enable falling.
- per_cnt: counts period_ticks 0..SETTLE_PERIODS-1 and clears on every state change.
- FSM:
  - IDLE: enable=1 -> DISCHARGE next cycle; cnt starts at 0.
  - DISCHARGE: duty=0. On the period_tick where per_cnt == SETTLE_PERIODS-1 -> RAMP, ramp_start=1 that cycle.
  - RAMP, step: on the period_tick where per_cnt == SETTLE_PERIODS-1, duty <= min(duty+STEP, MAX_DUTY). Sum computed 17-bit, no wrap.
  - RAMP, end: if duty was already MAX_DUTY at that point -> ramp_done=1, duty <= 0, -> DISCHARGE.
- sample_taken:
  - A pulse in RAMP sets the abort flag.
  - On the next period_tick: duty <= 0, -> DISCHARGE, flag cleared, no ramp_done.
  - Ignored in IDLE and DISCHARGE.
- Simultaneous sample_taken and the terminal period_tick: abort wins; duty <= 0, no ramp_done.
- enable=0 in any state: next cycle IDLE; duty = 0, cnt = 0, flags cleared, no pulses.
- Re-enable always begins with a full DISCHARGE.
- busy = (state != IDLE), registered with the state.

Decomposition:
- Package adc_pkg holds:
  - typedef enum logic [1:0] {IDLE, DISCHARGE, RAMP} ramp_state_t;
  - localparam ADC_W = 16, shared with the capture stage.
- One natural sub-module: pwm_core.
  - Contents: cnt, period_tick and the registered compare.
  - Ports: clk, reset, run, duty, pwm_out, period_tick.
- The FSM and per_cnt stay in the top.

Test Plan:
Bench parameters for all scenarios: PERIOD=16, STEP=4, MAX_DUTY=16, SETTLE_PERIODS=2.
- Reset mid-ramp with duty=8 -> all outputs 0 immediately, without waiting for a clock edge. After release with enable=1, busy goes to 1 one cycle later.
- enable=1 with no samples -> ramp_start 32 cycles after the DISCHARGE entry. duty steps 0,4,8,12,16, one step per 32 cycles. ramp_done 32 cycles after duty reaches 16, then duty=0.
- duty=8 -> pwm_out high exactly 8 of 16 cycles per period, and high exactly 1 cycle after cnt==0.
- sample_taken pulse with duty=12, at cnt=5 -> duty stays 12 until the next period_tick, then 0 and state DISCHARGE. No ramp_done.
- sample_taken on the same cycle as the terminal period_tick at duty=16 -> duty=0, ramp_done stays 0.
- enable=0 at cnt=9 in RAMP -> next cycle busy=0, duty=0, pwm_out=0. enable=1 again -> full 32-cycle discharge before ramp_start.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the ramp-compare ADC reference path.
//   ramp_state_t : sequencing states of the reference-ramp generator
//   ADC_W        : width of the duty / sampled-code bus, shared with the
//                  result-capture stage
package adc_pkg;

    localparam int ADC_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DISCHARGE = 2'd1,
        RAMP      = 2'd2
    } ramp_state_t;

endpackage

// File: rtl/pwm_ramp_gen_pwm_core.sv
// PWM period counter and registered duty compare.
//   clk         : system clock
//   reset       : asynchronous active-low reset
//   run         : 1 = count and drive; 0 = hold counter at 0, output low
//   duty        : compare threshold, sampled every cycle
//   pwm_out     : registered (cnt < duty), one cycle behind the counter
//   period_tick : high on the last count of a period (cnt == PERIOD-1)
module pwm_core
    import adc_pkg::*;
#(
    parameter int PERIOD = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [ADC_W-1:0] duty,
    output logic             pwm_out,
    output logic             period_tick
);

    localparam logic [ADC_W-1:0] CNT_LAST = ADC_W'(PERIOD - 1);

    logic [ADC_W-1:0] cnt_q;
    logic [ADC_W-1:0] cnt_d;
    logic             pwm_q;
    logic             pwm_d;

    always_comb begin
        cnt_d = '0;
        if (run) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + ADC_W'(1);
        end
        // Gating with run forces the output low on the same edge the
        // counter is cleared, so a stop never leaves a stray high cycle.
        pwm_d = run && (cnt_q < duty);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign period_tick = run && (cnt_q == CNT_LAST);
    assign pwm_out     = pwm_q;

endmodule

// File: rtl/pwm_ramp_gen.sv
// Reference-ramp generator for the ramp-compare ADC. Steps the PWM duty
// up by STEP every SETTLE_PERIODS PWM periods from 0 to MAX_DUTY; a sample
// from the capture stage aborts the ramp, which restarts after a discharge
// interval of SETTLE_PERIODS periods.
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   enable       : level; 0 returns to IDLE on the next edge
//   sample_taken : one-cycle pulse, comparator crossed
//   pwm_out      : registered PWM drive to the RC filter
//   duty_cycle   : current duty, also the sampled code
//   ramp_start   : one-cycle pulse on entry to RAMP
//   ramp_done    : one-cycle pulse when MAX_DUTY held a full step unsampled
//   busy         : state != IDLE
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | disabled; counter held at 0, duty 0, PWM low
// DISCHARGE | duty 0 for SETTLE_PERIODS periods to drain the RC filter
// RAMP      | duty steps up each SETTLE_PERIODS periods until sample/end
module pwm_ramp_gen
    import adc_pkg::*;
#(
    parameter int PERIOD         = 256,
    parameter int STEP           = 1,
    parameter int MAX_DUTY       = 255,
    parameter int SETTLE_PERIODS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sample_taken,
    output logic             pwm_out,
    output logic [ADC_W-1:0] duty_cycle,
    output logic             ramp_start,
    output logic             ramp_done,
    output logic             busy
);

    localparam logic [ADC_W-1:0] STEP_W      = ADC_W'(STEP);
    localparam logic [ADC_W-1:0] MAX_W       = ADC_W'(MAX_DUTY);
    localparam logic [ADC_W-1:0] SETTLE_LAST = ADC_W'(SETTLE_PERIODS - 1);

    ramp_state_t      state_q, state_d;
    logic [ADC_W-1:0] duty_q, duty_d;
    logic [ADC_W-1:0] per_cnt_q, per_cnt_d;
    logic             abort_q, abort_d;
    logic             ramp_start_q, ramp_start_d;
    logic             ramp_done_q, ramp_done_d;
    logic             busy_q;

    logic             run;
    logic             period_tick;
    logic             terminal;
    logic [ADC_W:0]   duty_sum;
    logic [ADC_W-1:0] duty_next;

    // Dropping enable stops the counter and PWM on the same edge the FSM
    // returns to IDLE.
    assign run = enable && (state_q != IDLE);

    pwm_core #(
        .PERIOD(PERIOD)
    ) u_pwm_core (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .duty       (duty_q),
        .pwm_out    (pwm_out),
        .period_tick(period_tick)
    );

    assign terminal  = period_tick && (per_cnt_q == SETTLE_LAST);
    // One extra bit so a large STEP saturates instead of wrapping.
    assign duty_sum  = {1'b0, duty_q} + {1'b0, STEP_W};
    assign duty_next = (duty_sum > {1'b0, MAX_W}) ? MAX_W : duty_sum[ADC_W-1:0];

    always_comb begin
        state_d      = state_q;
        duty_d       = duty_q;
        per_cnt_d    = per_cnt_q;
        abort_d      = abort_q;
        ramp_start_d = 1'b0;
        ramp_done_d  = 1'b0;

        if (!enable) begin
            state_d   = IDLE;
            duty_d    = '0;
            per_cnt_d = '0;
            abort_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = DISCHARGE;
                    duty_d    = '0;
                    per_cnt_d = '0;
                    abort_d   = 1'b0;
                end
                DISCHARGE: begin
                    duty_d = '0;
                    if (terminal) begin
                        state_d      = RAMP;
                        per_cnt_d    = '0;
                        ramp_start_d = 1'b1;
                    end else if (period_tick) begin
                        per_cnt_d = per_cnt_q + ADC_W'(1);
                    end
                end
                RAMP: begin
                    if (sample_taken) begin
                        abort_d = 1'b1;
                    end
                    if (period_tick) begin
                        // A sample landing on the tick itself counts too, so
                        // abort takes priority over the end-of-ramp pulse.
                        if (abort_q || sample_taken) begin
                            state_d   = DISCHARGE;
                            duty_d    = '0;
                            per_cnt_d = '0;
                            abort_d   = 1'b0;
                        end else if (terminal) begin
                            per_cnt_d = '0;
                            if (duty_q == MAX_W) begin
                                state_d     = DISCHARGE;
                                duty_d      = '0;
                                ramp_done_d = 1'b1;
                            end else begin
                                duty_d = duty_next;
                            end
                        end else begin
                            per_cnt_d = per_cnt_q + ADC_W'(1);
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    duty_d    = '0;
                    per_cnt_d = '0;
                    abort_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            duty_q       <= '0;
            per_cnt_q    <= '0;
            abort_q      <= 1'b0;
            ramp_start_q <= 1'b0;
            ramp_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            duty_q       <= duty_d;
            per_cnt_q    <= per_cnt_d;
            abort_q      <= abort_d;
            ramp_start_q <= ramp_start_d;
            ramp_done_q  <= ramp_done_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign duty_cycle = duty_q;
    assign ramp_start = ramp_start_q;
    assign ramp_done  = ramp_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pwm_ramp_gen.sv
module tb_pwm_ramp_gen;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        sample_taken;
    logic        pwm_out;
    logic [15:0] duty_cycle;
    logic        ramp_start;
    logic        ramp_done;
    logic        busy;

    pwm_ramp_gen #(
        .PERIOD        (16),
        .STEP          (4),
        .MAX_DUTY      (16),
        .SETTLE_PERIODS(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sample_taken(sample_taken),
        .pwm_out     (pwm_out),
        .duty_cycle  (duty_cycle),
        .ramp_start  (ramp_start),
        .ramp_done   (ramp_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_t;

    sb_t exp_q[$];
    int  total    = 0;
    int  bad      = 0;
    int  rel      = 0;
    int  done_cnt = 0;
    int  hi;

    always @(negedge clk) begin
        if (ramp_done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic go_to(input int t);
        while (rel < t) tick();
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        sb_t it;
        it.tag = tag;
        it.val = val;
        exp_q.push_back(it);
    endtask

    task automatic chk(input logic [31:0] obs);
        sb_t it;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            it = exp_q.pop_front();
            assert (obs === it.val) else begin
                bad++;
                $error("FAIL %s observed=%0d expected=%0d", it.tag, obs, it.val);
            end
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; sample_taken = 1'b0;
        repeat (3) tick();
        push("rst_pwm", 0); push("rst_duty", 0); push("rst_start", 0);
        push("rst_done", 0); push("rst_busy", 0);
        chk(32'(pwm_out)); chk(32'(duty_cycle)); chk(32'(ramp_start));
        chk(32'(ramp_done)); chk(32'(busy));

        // Bring-up: DISCHARGE entry one edge after enable.
        reset = 1'b1; enable = 1'b1;
        push("busy_after_en", 1);
        tick(); chk(32'(busy));
        rel = 0;
        push("disch_no_start", 0); go_to(31); chk(32'(ramp_start));
        push("ramp_start", 1); push("ramp_start_duty", 0);
        go_to(32); chk(32'(ramp_start)); chk(32'(duty_cycle));
        rel = 0;
        push("start_one_cycle", 0); go_to(1); chk(32'(ramp_start));

        // Full ramp, no samples.
        for (int k = 1; k <= 4; k++) begin
            push("duty_hold", 32'(4 * (k - 1))); go_to(32 * k - 1); chk(32'(duty_cycle));
            push("duty_step", 32'(4 * k));       go_to(32 * k);     chk(32'(duty_cycle));
            if (k == 2) begin
                push("pwm_cnt15", 0); chk(32'(pwm_out));
                hi = 0;
                for (int i = 0; i < 16; i++) begin
                    go_to(65 + i);
                    if (i == 0) begin
                        push("pwm_after_cnt0", 1); chk(32'(pwm_out));
                    end
                    hi += int'(pwm_out);
                end
                push("pwm_high_count", 8); chk(32'(hi));
            end
        end
        push("done_early", 0); go_to(159); chk(32'(ramp_done));
        push("ramp_done", 1); push("done_duty", 0);
        go_to(160); chk(32'(ramp_done)); chk(32'(duty_cycle));
        push("done_pulse", 0); push("done_busy", 1);
        go_to(161); chk(32'(ramp_done)); chk(32'(busy));
        push("restart_after_done", 1); go_to(192); chk(32'(ramp_start));

        // Sample at duty 12, cnt 5: abort on the next period tick.
        rel = 0;
        go_to(101); sample_taken = 1'b1;
        go_to(102); sample_taken = 1'b0;
        push("abort_hold", 12); go_to(111); chk(32'(duty_cycle));
        push("abort_duty", 0); push("abort_no_done", 0);
        go_to(112); chk(32'(duty_cycle)); chk(32'(ramp_done));
        push("abort_disch", 0); go_to(143); chk(32'(ramp_start));
        push("abort_restart", 1); go_to(144); chk(32'(ramp_start));

        // Sample coincident with the terminal tick at duty 16.
        rel = 0;
        push("sim_pre_duty", 16); go_to(159); chk(32'(duty_cycle));
        sample_taken = 1'b1;
        push("sim_duty", 0); push("sim_no_done", 0);
        go_to(160); sample_taken = 1'b0;
        chk(32'(duty_cycle)); chk(32'(ramp_done));
        push("done_total", 1); go_to(161); chk(32'(done_cnt));
        push("sim_restart", 1); go_to(192); chk(32'(ramp_start));

        // enable drop at cnt 9 with duty 12.
        rel = 0;
        push("pre_dis_pwm", 1); push("pre_dis_duty", 12);
        go_to(105); chk(32'(pwm_out)); chk(32'(duty_cycle));
        enable = 1'b0;
        push("dis_busy", 0); push("dis_duty", 0); push("dis_pwm", 0);
        go_to(106); chk(32'(busy)); chk(32'(duty_cycle)); chk(32'(pwm_out));
        go_to(108); enable = 1'b1;
        rel = 0;
        push("reen_busy", 1); go_to(1); chk(32'(busy));
        rel = 0;
        push("reen_no_start", 0); go_to(31); chk(32'(ramp_start));
        push("reen_start", 1); go_to(32); chk(32'(ramp_start));

        // Asynchronous reset mid-ramp at duty 8.
        rel = 0;
        push("pre_rst_duty", 8); go_to(70); chk(32'(duty_cycle));
        #2 reset = 1'b0;
        #1;
        push("arst_pwm", 0); push("arst_duty", 0); push("arst_start", 0);
        push("arst_done", 0); push("arst_busy", 0);
        chk(32'(pwm_out)); chk(32'(duty_cycle)); chk(32'(ramp_start));
        chk(32'(ramp_done)); chk(32'(busy));
        #2 reset = 1'b1;
        push("busy_after_release", 1);
        tick(); chk(32'(busy));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
